// File: rtl/fp_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// fp_addsub_arbiter
// Shares one fixed-latency FpCustomAddSub core between ReqNum requesters.
// A round-robin arbiter picks at most one eligible request per cycle, the
// operands are registered into the core together with a new-data strobe, and
// a tag pipeline that mirrors the core latency carries the requester index so
// that each result is routed back to the requester that issued it.
//
// Ports:
//   Clk_i, Rst_i        clock, synchronous active-high reset
//   ReqA_i, ReqB_i      per-requester operands, slice i = [i*InOutWidth +: InOutWidth]
//   ReqAddSub_i         per-requester op select (0 = add, 1 = sub)
//   ReqValid_i          per-requester request pending
//   ReqReady_o          one-hot combinational grant
//   CoreA_o, CoreB_o,
//   CoreAddSub_o,
//   CoreNd_o            registered operands/strobe into the shared core
//   CoreResult_i,
//   CoreResultValid_i   core result and its valid
//   RspResult_o         registered result, shared by all requesters
//   RspValid_o          registered one-hot owner of RspResult_o (1-cycle pulse)
//   Busy_o              any operation in flight
//   Error_o             sticky core-valid / tag-valid disagreement
// -----------------------------------------------------------------------------
module fp_addsub_arbiter #(
    parameter int ManWidth       = 16,
    parameter int ExpWidth       = 6,
    parameter int ReqNum         = 4,
    parameter int Latency        = 5,
    parameter int MaxOutstanding = 3
) (
    input  logic                               Clk_i,
    input  logic                               Rst_i,
    input  logic [ReqNum*(1+ExpWidth+ManWidth)-1:0] ReqA_i,
    input  logic [ReqNum*(1+ExpWidth+ManWidth)-1:0] ReqB_i,
    input  logic [ReqNum-1:0]                  ReqAddSub_i,
    input  logic [ReqNum-1:0]                  ReqValid_i,
    output logic [ReqNum-1:0]                  ReqReady_o,
    output logic [ExpWidth+ManWidth:0]         CoreA_o,
    output logic [ExpWidth+ManWidth:0]         CoreB_o,
    output logic                               CoreAddSub_o,
    output logic                               CoreNd_o,
    input  logic [ExpWidth+ManWidth:0]         CoreResult_i,
    input  logic                               CoreResultValid_i,
    output logic [ExpWidth+ManWidth:0]         RspResult_o,
    output logic [ReqNum-1:0]                  RspValid_o,
    output logic                               Busy_o,
    output logic                               Error_o
);

    localparam int InOutWidth = 1 + ExpWidth + ManWidth;
    localparam int TagWidth   = (ReqNum > 2) ? $clog2(ReqNum) : 1;
    localparam int CntWidth   = $clog2(MaxOutstanding + 1);
    localparam int BlankWidth = $clog2(Latency + 1);

    // Issue stage registers (the new-data stage carries its own tag so the
    // tag pipeline below lines up with the core's internal pipeline).
    logic [InOutWidth-1:0] core_a_q, core_a_d;
    logic [InOutWidth-1:0] core_b_q, core_b_d;
    logic                  core_op_q, core_op_d;
    logic                  nd_q, nd_d;
    logic [TagWidth-1:0]   nd_tag_q, nd_tag_d;

    // Tag pipeline: entry Latency is aligned with CoreResultValid_i.
    logic [Latency:0]      tag_vld_q;
    logic [TagWidth-1:0]   tag_idx_q [Latency+1];

    logic [TagWidth-1:0]   ptr_q, ptr_d;
    logic [CntWidth-1:0]   cnt_q [ReqNum];
    logic [CntWidth-1:0]   cnt_d [ReqNum];
    logic [BlankWidth-1:0] blank_q, blank_d;
    logic [InOutWidth-1:0] rsp_result_q, rsp_result_d;
    logic [ReqNum-1:0]     rsp_valid_q, rsp_valid_d;
    logic                  err_q, err_d;

    logic [ReqNum-1:0]     elig_s;
    logic                  grant_vld_s;
    logic [TagWidth-1:0]   grant_idx_s;
    logic                  ret_vld_s;
    logic [TagWidth-1:0]   ret_idx_s;

    assign ret_vld_s = tag_vld_q[Latency];
    assign ret_idx_s = tag_idx_q[Latency];

    // Round-robin search starting at the pointer; no grant while in reset.
    always_comb begin
        elig_s      = '0;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        for (int i = 0; i < ReqNum; i++) begin
            if (ReqValid_i[i] && (cnt_q[i] < CntWidth'(MaxOutstanding))) begin
                elig_s[i] = 1'b1;
            end else begin
                elig_s[i] = 1'b0;
            end
        end
        for (int k = 0; k < ReqNum; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= ReqNum) begin
                idx = idx - ReqNum;
            end else begin
                idx = idx;
            end
            if (!grant_vld_s && elig_s[idx]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = TagWidth'(idx);
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
        if (Rst_i) begin
            grant_vld_s = 1'b0;
        end else begin
            grant_vld_s = grant_vld_s;
        end
        if (grant_vld_s) begin
            ReqReady_o = ReqNum'(1) << grant_idx_s;
        end else begin
            ReqReady_o = '0;
        end
    end

    // Next-state for issue registers, pointer, counters, response and error.
    always_comb begin
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        core_op_d    = core_op_q;
        nd_d         = grant_vld_s;
        nd_tag_d     = grant_idx_s;
        ptr_d        = ptr_q;
        rsp_result_d = rsp_result_q;
        rsp_valid_d  = '0;
        if (grant_vld_s) begin
            core_a_d  = ReqA_i[grant_idx_s*InOutWidth +: InOutWidth];
            core_b_d  = ReqB_i[grant_idx_s*InOutWidth +: InOutWidth];
            core_op_d = ReqAddSub_i[grant_idx_s];
            if (grant_idx_s == TagWidth'(ReqNum - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_s + TagWidth'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
        // Routing relies on the tag pipeline only; the core's valid is unreset.
        if (ret_vld_s) begin
            rsp_result_d = CoreResult_i;
            rsp_valid_d  = ReqNum'(1) << ret_idx_s;
        end else begin
            rsp_valid_d  = '0;
        end
        // The decrement is taken on the edge that raises RspValid_o, so the
        // requester can be re-granted while its response pulse is visible.
        for (int i = 0; i < ReqNum; i++) begin
            case ({grant_vld_s && (grant_idx_s == TagWidth'(i)),
                   ret_vld_s && (ret_idx_s == TagWidth'(i))})
                2'b10:   cnt_d[i] = cnt_q[i] + CntWidth'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CntWidth'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        if (blank_q != BlankWidth'(0)) begin
            blank_d = blank_q - BlankWidth'(1);
            err_d   = err_q;
        end else begin
            blank_d = blank_q;
            err_d   = err_q | (ret_vld_s != CoreResultValid_i);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge Clk_i) begin
        if (Rst_i) begin
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_op_q    <= 1'b0;
            nd_q         <= 1'b0;
            nd_tag_q     <= '0;
            tag_vld_q    <= '0;
            ptr_q        <= '0;
            blank_q      <= BlankWidth'(Latency);
            rsp_result_q <= '0;
            rsp_valid_q  <= '0;
            err_q        <= 1'b0;
            for (int k = 0; k <= Latency; k++) begin
                tag_idx_q[k] <= '0;
            end
            for (int i = 0; i < ReqNum; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            core_op_q    <= core_op_d;
            nd_q         <= nd_d;
            nd_tag_q     <= nd_tag_d;
            tag_vld_q    <= {tag_vld_q[Latency-1:0], nd_q};
            ptr_q        <= ptr_d;
            blank_q      <= blank_d;
            rsp_result_q <= rsp_result_d;
            rsp_valid_q  <= rsp_valid_d;
            err_q        <= err_d;
            tag_idx_q[0] <= nd_tag_q;
            for (int k = 1; k <= Latency; k++) begin
                tag_idx_q[k] <= tag_idx_q[k-1];
            end
            for (int i = 0; i < ReqNum; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign CoreA_o      = core_a_q;
    assign CoreB_o      = core_b_q;
    assign CoreAddSub_o = core_op_q;
    assign CoreNd_o     = nd_q;
    assign RspResult_o  = rsp_result_q;
    assign RspValid_o   = rsp_valid_q;
    assign Error_o      = err_q;
    assign Busy_o       = (|tag_vld_q) | nd_q | (|rsp_valid_q);

endmodule
